apb_regfile_slave: RTL and testbench



---
 rtl/apb_regfile_slave.sv | 126 ++++++++++++
 tb/tb_apb_regfile_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB completer with a NUM_REGS x 32-bit register bank and WAIT_STATES extra access cycles.
// Optional macro APB_SLV_PSLVERR_EN: answer out-of-window or misaligned accesses with Pslverr=1.
module apb_regfile_slave #(
  parameter int          SEL_IDX     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0020,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [1:0]  Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int AW = $clog2(NUM_REGS) + 2;
  localparam int IW = AW - 2;

`ifdef APB_SLV_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [31:0]   regs [NUM_REGS];
  logic [IW-1:0] lat_idx;
  logic          lat_write;
  logic          lat_hit;
  logic [31:0]   lat_wdata;
  logic [3:0]    cnt;

  logic          sel;
  logic          hit;
  logic [IW-1:0] idx;
  logic          unused_psel;

  assign sel         = Psel[SEL_IDX];
  assign unused_psel = ^Psel;
  assign hit         = (Paddr[31:AW] == BASE_ADDR[31:AW]) && (Paddr[1:0] == 2'b00);
  assign idx         = Paddr[AW-1:2];

  // With no wait states the response leaves on the setup edge, so it comes from the live bus.
  logic          rd_hit;
  logic          rd_write;
  logic [IW-1:0] rd_idx;
  logic [31:0]   rdata_next;
  logic          err_next;

  always_comb begin
    rd_hit   = lat_hit;
    rd_write = lat_write;
    rd_idx   = lat_idx;
    if (state == IDLE) begin
      rd_hit   = hit;
      rd_write = Pwrite;
      rd_idx   = idx;
    end
    rdata_next = (rd_hit && !rd_write) ? regs[rd_idx] : 32'h0;
    err_next   = ERR_EN & !rd_hit;
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state     <= IDLE;
      Prdata    <= 32'h0;
      Pready    <= 1'b0;
      Pslverr   <= 1'b0;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_hit   <= 1'b0;
      lat_wdata <= 32'h0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (sel && !Penable) begin
            lat_idx   <= idx;
            lat_write <= Pwrite;
            lat_hit   <= hit;
            lat_wdata <= Pwdata;
            cnt       <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state   <= DONE;
              Pready  <= 1'b1;
              Prdata  <= rdata_next;
              Pslverr <= err_next;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!sel) begin
            state <= IDLE;
          end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= DONE;
            Pready  <= 1'b1;
            Prdata  <= rdata_next;
            Pslverr <= err_next;
          end
        end
        DONE: begin
          // The write lands only if the bridge is still presenting the access phase.
          if (lat_write && lat_hit && sel && Penable) regs[lat_idx] <= lat_wdata;
          state   <= IDLE;
          Pready  <= 1'b0;
          Prdata  <= 32'h0;
          Pslverr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: two slaves share one APB bus (Psel[0] with one wait state, Psel[1] with none).
// A transaction-level model predicts Pready/Prdata/Pslverr for both on every cycle.
`timescale 1ns/1ps
module tb_apb_regfile_slave;

  localparam logic [31:0] BASE = 32'h0000_0020;
  localparam int          NREG = 8;
  localparam int          WS0  = 1;
  localparam int          WS1  = 0;

`ifdef APB_SLV_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        Hclk;
  logic        Hreset;
  logic [1:0]  Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int n_cmp = 0;
  int n_bad = 0;

  apb_regfile_slave #(.SEL_IDX(0), .BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_STATES(WS0)) dut_a (
    .Hclk(Hclk), .Hreset(Hreset), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

  apb_regfile_slave #(.SEL_IDX(1), .BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_STATES(WS1)) dut_b (
    .Hclk(Hclk), .Hreset(Hreset), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction model: a setup at cycle c completes WAIT_STATES+1 access cycles later unless sel drops.
  int          cyc = 0;
  logic [31:0] mem [2][NREG];
  bit          pend [2];
  bit          exp_ready [2];
  bit          m_write [2];
  bit          m_hit [2];
  int          m_idx [2];
  int          ready_at [2];
  logic [31:0] m_wdata [2];
  logic [31:0] exp_rdata [2];
  bit          exp_err [2];
  bit          s_sel;

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(NREG * 4)) && (a[1:0] == 2'b00);
  endfunction

  always @(posedge Hclk) begin
    cyc++;
    for (int s = 0; s < 2; s++) begin
      s_sel = Psel[s];
      if (Hreset) begin
        pend[s]      = 1'b0;
        exp_ready[s] = 1'b0;
        for (int k = 0; k < NREG; k++) mem[s][k] = 32'h0;
      end else if (exp_ready[s]) begin
        if (m_write[s] && m_hit[s] && s_sel && Penable) mem[s][m_idx[s]] = m_wdata[s];
        exp_ready[s] = 1'b0;
        pend[s]      = 1'b0;
      end else if (pend[s]) begin
        if (!s_sel) pend[s] = 1'b0;
        else if (cyc == ready_at[s]) exp_ready[s] = 1'b1;
      end else if (s_sel && !Penable) begin
        pend[s]     = 1'b1;
        m_write[s]  = Pwrite;
        m_hit[s]    = in_window(Paddr);
        m_idx[s]    = m_hit[s] ? int'((Paddr - BASE) / 4) : 0;
        m_wdata[s]  = Pwdata;
        ready_at[s] = cyc + ((s == 0) ? WS0 : WS1);
        if (cyc == ready_at[s]) exp_ready[s] = 1'b1;
      end
      if (exp_ready[s]) begin
        exp_rdata[s] = (!m_write[s] && m_hit[s]) ? mem[s][m_idx[s]] : 32'h0;
        exp_err[s]   = ERR_EN && !m_hit[s];
      end
    end
  end

  always @(negedge Hclk) begin
    if (cyc > 0) begin
      for (int s = 0; s < 2; s++) begin
        checkOutput($sformatf("pready_s%0d_cyc%0d", s, cyc), {31'h0, pready[s]}, {31'h0, exp_ready[s]});
        if (exp_ready[s]) begin
          checkOutput($sformatf("pslverr_s%0d_cyc%0d", s, cyc), {31'h0, pslverr[s]}, {31'h0, exp_err[s]});
          if (!m_write[s])
            checkOutput($sformatf("prdata_s%0d_cyc%0d", s, cyc), prdata[s], exp_rdata[s]);
        end
      end
    end
  end

  task automatic applyStimulus(input int tgt, input logic [1:0] psel_v, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int drop_at, input bit scramble, input int max_acc,
                               output logic [31:0] rdata, output logic err,
                               output bit got, output int nacc);
    got   = 1'b0;
    nacc  = 0;
    rdata = 32'h0;
    err   = 1'b0;
    Psel    = psel_v;
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = wdata;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    for (int acc = 1; acc <= max_acc; acc++) begin
      if (acc == drop_at) Psel = 2'b00;
      if (scramble) begin
        Paddr  = $urandom;
        Pwdata = $urandom;
      end
      @(negedge Hclk);
      if (pready[tgt]) begin
        got   = 1'b1;
        nacc  = acc;
        rdata = prdata[tgt];
        err   = pslverr[tgt];
      end
      @(posedge Hclk); #1;
      if (got) break;
    end
    Psel    = 2'b00;
    Penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  bit          gt;
  int          na;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Hreset = 1'b1; Psel = 2'b00; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h0; Pwdata = 32'h0;
    repeat (3) @(posedge Hclk);
    #1 Hreset = 1'b0;
    @(negedge Hclk);
    checkOutput("reset_pready", {31'h0, pready[0]}, 32'h0);
    checkOutput("reset_prdata", prdata[0], 32'h0);
    @(posedge Hclk); #1;

    // Slave A, one wait state: Pready lands in access cycle 2.
    applyStimulus(0, 2'b01, 1'b1, 32'h20, 32'hAA, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_wr20_ready", {31'h0, gt}, 32'h1);
    checkOutput("a_wr20_latency", 32'(na), 32'd2);
    applyStimulus(0, 2'b01, 1'b0, 32'h20, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd20_data", rd, 32'hAA);
    checkOutput("a_rd20_err", {31'h0, er}, 32'h0);
    checkOutput("a_rd20_latency", 32'(na), 32'd2);

    // Slave B, no wait states, back-to-back write then read.
    applyStimulus(1, 2'b10, 1'b1, 32'h24, 32'hBB, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("b_wr24_latency", 32'(na), 32'd1);
    applyStimulus(1, 2'b10, 1'b0, 32'h24, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("b_rd24_data", rd, 32'hBB);
    checkOutput("b_rd24_latency", 32'(na), 32'd1);
    applyStimulus(0, 2'b01, 1'b0, 32'h24, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd24_untouched", rd, 32'h0);

    // Misses: out of window and misaligned.
    applyStimulus(0, 2'b01, 1'b1, 32'h40, 32'hDEAD, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_wr40_err", {31'h0, er}, {31'h0, ERR_EN});
    applyStimulus(0, 2'b01, 1'b0, 32'h40, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd40_data", rd, 32'h0);
    checkOutput("a_rd40_err", {31'h0, er}, {31'h0, ERR_EN});
    applyStimulus(0, 2'b01, 1'b0, 32'h22, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd22_data", rd, 32'h0);
    checkOutput("a_rd22_err", {31'h0, er}, {31'h0, ERR_EN});
    applyStimulus(0, 2'b01, 1'b0, 32'h20, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd20_after_miss", rd, 32'hAA);

    // Top register of the window.
    applyStimulus(0, 2'b01, 1'b1, 32'h3C, 32'hC0FFEE, 0, 1'b0, 5, rd, er, gt, na);
    applyStimulus(0, 2'b01, 1'b0, 32'h3C, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd3c_data", rd, 32'hC0FFEE);

    // Select dropped during the wait-state cycle.
    applyStimulus(0, 2'b01, 1'b1, 32'h28, 32'h55, 1, 1'b0, 3, rd, er, gt, na);
    checkOutput("a_wr28_aborted", {31'h0, gt}, 32'h0);
    applyStimulus(0, 2'b01, 1'b0, 32'h28, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd28_data", rd, 32'h0);

    // The other select bit reaches slave B only.
    applyStimulus(0, 2'b10, 1'b1, 32'h2C, 32'h77, 0, 1'b0, 3, rd, er, gt, na);
    checkOutput("a_wr2c_no_ready", {31'h0, gt}, 32'h0);
    applyStimulus(0, 2'b01, 1'b0, 32'h2C, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd2c_data", rd, 32'h0);
    applyStimulus(1, 2'b10, 1'b0, 32'h2C, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("b_rd2c_data", rd, 32'h77);

    // Bus scrambled during the access phase; the latched write must land.
    applyStimulus(0, 2'b01, 1'b1, 32'h30, 32'h1234, 0, 1'b1, 5, rd, er, gt, na);
    applyStimulus(0, 2'b01, 1'b0, 32'h30, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd30_data", rd, 32'h1234);

    // Reset during the wait-state cycle of a write.
    Psel = 2'b01; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h34; Pwdata = 32'h99;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    Hreset  = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b0; Psel = 2'b00; Penable = 1'b0;
    @(negedge Hclk);
    checkOutput("rst_mid_pready", {31'h0, pready[0]}, 32'h0);
    checkOutput("rst_mid_prdata", prdata[0], 32'h0);
    checkOutput("rst_mid_pslverr", {31'h0, pslverr[0]}, 32'h0);
    @(posedge Hclk); #1;
    applyStimulus(0, 2'b01, 1'b0, 32'h20, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd20_after_rst", rd, 32'h0);
    applyStimulus(0, 2'b01, 1'b0, 32'h34, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("a_rd34_after_rst", rd, 32'h0);
    applyStimulus(1, 2'b10, 1'b0, 32'h24, 32'h0, 0, 1'b0, 5, rd, er, gt, na);
    checkOutput("b_rd24_after_rst", rd, 32'h0);

    repeat (3) @(posedge Hclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
